// File: rtl/find_topk_if.sv
// Sample stream in, ranked top-K results out for find_topk.
// The source side uses master; find_topk itself uses slave.
interface find_topk_if #(
    parameter int DW   = 5,
    parameter int K    = 2,
    parameter int IDXW = 8
);
    logic [DW-1:0]     datain;
    logic              datain_ena;
    logic [K*DW-1:0]   topk_data;
    logic [K*IDXW-1:0] topk_idx;
    logic [K-1:0]      topk_vld;
    logic [IDXW-1:0]   sample_cnt;
    logic              overflow;
    logic              dataout_ena;

    modport master (
        output datain, datain_ena,
        input  topk_data, topk_idx, topk_vld, sample_cnt, overflow, dataout_ena
    );

    modport slave (
        input  datain, datain_ena,
        output topk_data, topk_idx, topk_vld, sample_cnt, overflow, dataout_ena
    );
endinterface

// File: rtl/find_topk.sv
// Streaming top-K extractor. Keeps a sorted working set of the K best samples of a burst and
// publishes it, with the sample count, on the first idle cycle after the burst.
module find_topk #(
    parameter int DW       = 5,
    parameter int K        = 2,
    parameter int IDXW     = 8,
    parameter bit SIGNED   = 1'b0,
    parameter bit FIND_MIN = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    find_topk_if.slave bus
);
    typedef enum logic {IDLE, ACCUM} state_t;

    localparam logic [IDXW-1:0] CNT_MAX = '1;

    state_t state, state_nxt;
    logic   start, take, publish;

    logic [DW-1:0]   wdata [K];
    logic [IDXW-1:0] widx  [K];
    logic [K-1:0]    wvld;
    logic [IDXW-1:0] wcnt;
    logic            wovf;

    logic [DW-1:0]   cur_data [K];
    logic [IDXW-1:0] cur_idx  [K];
    logic [K-1:0]    cur_vld;
    logic [DW-1:0]   nxt_data [K];
    logic [IDXW-1:0] nxt_idx  [K];
    logic [K-1:0]    nxt_vld;
    logic [IDXW-1:0] samp_idx;
    logic            ins_hit;
    int              ins_pos;

    logic [K*DW-1:0]   topk_data_q;
    logic [K*IDXW-1:0] topk_idx_q;
    logic [K-1:0]      topk_vld_q;
    logic [IDXW-1:0]   sample_cnt_q;
    logic              overflow_q;
    logic              dataout_ena_q;

    function automatic logic better(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic gt;
        if (SIGNED) gt = ($signed(a) > $signed(b));
        else        gt = (a > b);
        if (FIND_MIN) return (a != b) && !gt;
        return gt;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.datain_ena)  state_nxt = ACCUM;
            ACCUM:   if (!bus.datain_ena) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start   = (state == IDLE) && bus.datain_ena;
        take    = bus.datain_ena;
        publish = (state == ACCUM) && !bus.datain_ena;
    end

    // A new burst sees an empty set, so the first sample always lands at rank 0 with idx 0.
    always_comb begin
        samp_idx = start ? '0 : wcnt;
        cur_vld  = start ? '0 : wvld;
        ins_hit  = 1'b0;
        ins_pos  = 0;
        for (int r = 0; r < K; r++) begin
            cur_data[r] = start ? '0 : wdata[r];
            cur_idx[r]  = start ? '0 : widx[r];
        end
        for (int r = K - 1; r >= 0; r--) begin
            if (!cur_vld[r] || better(bus.datain, cur_data[r])) begin
                ins_hit = 1'b1;
                ins_pos = r;
            end
        end
        for (int r = 0; r < K; r++) begin
            nxt_data[r] = cur_data[r];
            nxt_idx[r]  = cur_idx[r];
            nxt_vld[r]  = cur_vld[r];
            if (ins_hit && r == ins_pos) begin
                nxt_data[r] = bus.datain;
                nxt_idx[r]  = samp_idx;
                nxt_vld[r]  = 1'b1;
            end else if (ins_hit && r > ins_pos) begin
                nxt_data[r] = cur_data[(r > 0) ? r - 1 : 0];
                nxt_idx[r]  = cur_idx[(r > 0) ? r - 1 : 0];
                nxt_vld[r]  = cur_vld[(r > 0) ? r - 1 : 0];
            end
        end
    end

    // The counter sticks at its maximum; reaching it again marks the burst as overflowed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < K; r++) begin
                wdata[r] <= '0;
                widx[r]  <= '0;
            end
            wvld <= '0;
            wcnt <= '0;
            wovf <= 1'b0;
        end else if (take) begin
            for (int r = 0; r < K; r++) begin
                wdata[r] <= nxt_data[r];
                widx[r]  <= nxt_idx[r];
            end
            wvld <= nxt_vld;
            if (start) begin
                wcnt <= IDXW'(1);
                wovf <= 1'b0;
            end else if (wcnt == CNT_MAX) begin
                wovf <= 1'b1;
            end else begin
                wcnt <= wcnt + IDXW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            topk_data_q   <= '0;
            topk_idx_q    <= '0;
            topk_vld_q    <= '0;
            sample_cnt_q  <= '0;
            overflow_q    <= 1'b0;
            dataout_ena_q <= 1'b0;
        end else begin
            dataout_ena_q <= publish;
            if (publish) begin
                for (int r = 0; r < K; r++) begin
                    topk_data_q[r*DW +: DW]   <= wdata[r];
                    topk_idx_q[r*IDXW +: IDXW] <= widx[r];
                end
                topk_vld_q   <= wvld;
                sample_cnt_q <= wcnt;
                overflow_q   <= wovf;
            end
        end
    end

    assign bus.topk_data   = topk_data_q;
    assign bus.topk_idx    = topk_idx_q;
    assign bus.topk_vld    = topk_vld_q;
    assign bus.sample_cnt  = sample_cnt_q;
    assign bus.overflow    = overflow_q;
    assign bus.dataout_ena = dataout_ena_q;
endmodule

// File: tb/tb_find_topk.sv
// Scoreboard bench for find_topk: four parameterisations, expected publications queued when a
// burst is driven and popped whenever a DUT pulses dataout_ena.
module tb_find_topk;
    typedef struct {
        logic [63:0] data;
        logic [63:0] idx;
        logic [63:0] vld;
        logic [63:0] cnt;
        logic [63:0] ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    find_topk_if #(.DW(5), .K(2), .IDXW(8)) if_a ();
    find_topk_if #(.DW(5), .K(4), .IDXW(8)) if_b ();
    find_topk_if #(.DW(5), .K(2), .IDXW(8)) if_c ();
    find_topk_if #(.DW(5), .K(2), .IDXW(3)) if_d ();

    find_topk #(.DW(5), .K(2), .IDXW(8), .SIGNED(1'b0), .FIND_MIN(1'b0)) u_a (.clk(clk), .rst(rst), .bus(if_a));
    find_topk #(.DW(5), .K(4), .IDXW(8), .SIGNED(1'b0), .FIND_MIN(1'b0)) u_b (.clk(clk), .rst(rst), .bus(if_b));
    find_topk #(.DW(5), .K(2), .IDXW(8), .SIGNED(1'b1), .FIND_MIN(1'b1)) u_c (.clk(clk), .rst(rst), .bus(if_c));
    find_topk #(.DW(5), .K(2), .IDXW(3), .SIGNED(1'b0), .FIND_MIN(1'b0)) u_d (.clk(clk), .rst(rst), .bus(if_d));

    exp_t q_a[$], q_b[$], q_c[$], q_d[$];
    exp_t e_a, e_b, e_c, e_d;
    int   burst[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic checkResult(input string tag, input logic [63:0] d, input logic [63:0] i,
                               input logic [63:0] v, input logic [63:0] c, input logic [63:0] o,
                               input exp_t e);
        checkOutput({tag, "_data"}, d, e.data);
        checkOutput({tag, "_idx"},  i, e.idx);
        checkOutput({tag, "_vld"},  v, e.vld);
        checkOutput({tag, "_cnt"},  c, e.cnt);
        checkOutput({tag, "_ovf"},  o, e.ovf);
    endtask

    function automatic exp_t mkExp(input logic [63:0] d, input logic [63:0] i, input logic [63:0] v,
                                   input logic [63:0] c, input logic [63:0] o);
        exp_t e;
        e.data = d; e.idx = i; e.vld = v; e.cnt = c; e.ovf = o;
        return e;
    endfunction

    // Reference for the default configuration: repeated selection of the largest remaining
    // sample, earliest one first among equals.
    function automatic exp_t modelTopk();
        exp_t e;
        bit   used [0:63];
        int   best;
        e = mkExp(0, 0, 0, 0, 0);
        foreach (used[i]) used[i] = 1'b0;
        for (int r = 0; r < 2; r++) begin
            best = -1;
            foreach (burst[i])
                if (!used[i] && (best < 0 || burst[i] > burst[best])) best = i;
            if (best >= 0) begin
                used[best] = 1'b1;
                e.data |= 64'(burst[best]) << (5 * r);
                e.idx  |= 64'((best > 255) ? 255 : best) << (8 * r);
                e.vld  |= 64'(1) << r;
            end
        end
        e.cnt = 64'((burst.size() > 255) ? 255 : burst.size());
        e.ovf = 64'(burst.size() > 255);
        return e;
    endfunction

    task automatic drive(input int sel, input logic ena, input int val);
        case (sel)
            0: begin if_a.datain_ena = ena; if_a.datain = 5'(val); end
            1: begin if_b.datain_ena = ena; if_b.datain = 5'(val); end
            2: begin if_c.datain_ena = ena; if_c.datain = 5'(val); end
            default: begin if_d.datain_ena = ena; if_d.datain = 5'(val); end
        endcase
    endtask

    // Drives the current burst, then drops datain_ena with junk on datain.
    task automatic applyStimulus(input int sel);
        foreach (burst[i]) begin
            @(posedge clk);
            #1 drive(sel, 1'b1, burst[i]);
        end
        @(posedge clk);
        #1 drive(sel, 1'b0, int'($urandom));
    endtask

    always @(negedge clk) begin
        if (if_a.dataout_ena === 1'b1) begin
            if (q_a.size() == 0) checkOutput("a_extra_pulse", 64'(if_a.dataout_ena), 0);
            else begin
                e_a = q_a.pop_front();
                checkResult("a", 64'(if_a.topk_data), 64'(if_a.topk_idx), 64'(if_a.topk_vld),
                            64'(if_a.sample_cnt), 64'(if_a.overflow), e_a);
            end
        end
        if (if_b.dataout_ena === 1'b1) begin
            if (q_b.size() == 0) checkOutput("b_extra_pulse", 64'(if_b.dataout_ena), 0);
            else begin
                e_b = q_b.pop_front();
                checkResult("b", 64'(if_b.topk_data), 64'(if_b.topk_idx), 64'(if_b.topk_vld),
                            64'(if_b.sample_cnt), 64'(if_b.overflow), e_b);
            end
        end
        if (if_c.dataout_ena === 1'b1) begin
            if (q_c.size() == 0) checkOutput("c_extra_pulse", 64'(if_c.dataout_ena), 0);
            else begin
                e_c = q_c.pop_front();
                checkResult("c", 64'(if_c.topk_data), 64'(if_c.topk_idx), 64'(if_c.topk_vld),
                            64'(if_c.sample_cnt), 64'(if_c.overflow), e_c);
            end
        end
        if (if_d.dataout_ena === 1'b1) begin
            if (q_d.size() == 0) checkOutput("d_extra_pulse", 64'(if_d.dataout_ena), 0);
            else begin
                e_d = q_d.pop_front();
                checkResult("d", 64'(if_d.topk_data), 64'(if_d.topk_idx), 64'(if_d.topk_vld),
                            64'(if_d.sample_cnt), 64'(if_d.overflow), e_d);
            end
        end
    end

    initial begin
        rst = 1'b1;
        for (int s = 0; s < 4; s++) drive(s, 1'b0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        checkOutput("rst_a_data", 64'(if_a.topk_data), 0);
        checkOutput("rst_a_vld",  64'(if_a.topk_vld), 0);
        checkOutput("rst_a_ena",  64'(if_a.dataout_ena), 0);
        checkOutput("rst_b_data", 64'(if_b.topk_data), 0);
        checkOutput("rst_b_cnt",  64'(if_b.sample_cnt), 0);
        checkOutput("rst_c_idx",  64'(if_c.topk_idx), 0);
        checkOutput("rst_d_ovf",  64'(if_d.overflow), 0);

        // Duplicate maximum: the earlier 31 holds rank 0.
        burst = '{0, 17, 3, 31, 9, 31, 2};
        q_a.push_back(mkExp(31 | (31 << 5), 3 | (5 << 8), 3, 7, 0));
        applyStimulus(0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("a_hold_data", 64'(if_a.topk_data), 31 | (31 << 5));
        checkOutput("a_hold_ena",  64'(if_a.dataout_ena), 0);

        burst = '{12};
        q_b.push_back(mkExp(12, 0, 1, 1, 0));
        applyStimulus(1);
        repeat (2) @(posedge clk);

        // Two bursts with a single idle cycle between them.
        burst = '{4, 9, 1};
        q_a.push_back(mkExp(9 | (4 << 5), 1, 3, 3, 0));
        applyStimulus(0);
        burst = '{2, 7};
        q_a.push_back(mkExp(7 | (2 << 5), 1, 3, 2, 0));
        applyStimulus(0);
        repeat (3) @(posedge clk);

        // Reset in the middle of a burst discards it without a pulse.
        foreach (burst[i]) burst[i] = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 drive(0, 1'b1, 10 + i);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 1'b0, 0);
        #1;
        checkOutput("midrst_data", 64'(if_a.topk_data), 0);
        checkOutput("midrst_vld",  64'(if_a.topk_vld), 0);
        checkOutput("midrst_cnt",  64'(if_a.sample_cnt), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        burst = '{5, 6};
        q_a.push_back(mkExp(6 | (5 << 5), 1, 3, 2, 0));
        applyStimulus(0);
        repeat (2) @(posedge clk);

        burst = '{-1, 5, -16};
        q_c.push_back(mkExp(64'h10 | (64'h1F << 5), 2, 3, 3, 0));
        applyStimulus(2);
        repeat (2) @(posedge clk);

        // Counter and index saturate at 7; the next burst clears the overflow flag.
        burst = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 30};
        q_d.push_back(mkExp(30 | (9 << 5), 7 | (7 << 3), 3, 7, 1));
        applyStimulus(3);
        burst = '{3, 1};
        q_d.push_back(mkExp(3 | (1 << 5), 1 << 3, 3, 2, 0));
        applyStimulus(3);
        repeat (2) @(posedge clk);

        for (int t = 0; t < 8; t++) begin
            burst.delete();
            for (int i = 0, n = $urandom_range(1, 12); i < n; i++)
                burst.push_back($urandom_range(0, 31));
            q_a.push_back(modelTopk());
            applyStimulus(0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (5) @(posedge clk);
        #1;
        checkOutput("a_pending", 64'(q_a.size()), 0);
        checkOutput("b_pending", 64'(q_b.size()), 0);
        checkOutput("c_pending", 64'(q_c.size()), 0);
        checkOutput("d_pending", 64'(q_d.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
